// File: rtl/sram_axi_bridge_mo.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge_mo
// Purpose  : Bridges the CPU inst (read-only) and data (read/write)
//            SRAM-like ports onto a single AXI3 master. Up to MAX_RD reads
//            may be outstanding per port, and one write. The data port wins
//            arbitration for the shared AR slot. Data reads and writes are
//            mutually exclusive, so data-port completions always come back
//            in request order.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            inst_*              - SRAM-like instruction port (reads only)
//            data_*              - SRAM-like data port (reads and writes)
//            ar*/r*              - AXI3 read address / read data channels
//            aw*/w*/b*           - AXI3 write address / data / response
// Revision : 1.0 - initial release
// ============================================================================
module sram_axi_bridge_mo #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int ID_W    = 4,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1,
    parameter int MAX_RD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    // instruction port
    input  logic              inst_req,
    input  logic [2:0]        inst_size,
    input  logic [AW-1:0]     inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DW-1:0]     inst_rdata,
    // data port
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [2:0]        data_size,
    input  logic [DW/8-1:0]   data_wstrb,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DW-1:0]     data_rdata,
    // AR channel
    output logic [ID_W-1:0]   arid,
    output logic [AW-1:0]     araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // R channel
    input  logic [ID_W-1:0]   rid,
    input  logic [DW-1:0]     rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AW channel
    output logic [ID_W-1:0]   awid,
    output logic [AW-1:0]     awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // W channel
    output logic [ID_W-1:0]   wid,
    output logic [DW-1:0]     wdata,
    output logic [DW/8-1:0]   wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B channel
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int              CW        = $clog2(MAX_RD + 1);
    localparam int              SW        = DW / 8;
    localparam logic [ID_W-1:0] c_inst_id = ID_W'(INST_ID);
    localparam logic [ID_W-1:0] c_data_id = ID_W'(DATA_ID);
    localparam logic [CW-1:0]   c_max_rd  = CW'(MAX_RD);

    // AR slot
    logic              r_arvalid;
    logic [AW-1:0]     r_araddr;
    logic [2:0]        r_arsize;
    logic [ID_W-1:0]   r_arid;
    // read bookkeeping
    logic              r_rready;
    logic [CW-1:0]     r_cnt_i;
    logic [CW-1:0]     r_cnt_d;
    // write path
    logic              r_wr_busy;
    logic              r_awvalid;
    logic              r_wvalid;
    logic [AW-1:0]     r_awaddr;
    logic [2:0]        r_awsize;
    logic [DW-1:0]     r_wdata;
    logic [SW-1:0]     r_wstrb;

    logic w_slot_free;
    logic w_data_rd_acc;
    logic w_inst_rd_acc;
    logic w_wr_acc;
    logic w_r_hs;
    logic w_inst_rok;
    logic w_data_rok;
    logic w_bready;
    logic w_b_hs;
    logic w_unused;

    // Response status and burst markers carry no information for single-beat
    // transfers, and errors are not reported back to the CPU.
    assign w_unused = ^{rresp, rlast, bid, bresp};

    // ------------------------------------------------------------------
    // Request acceptance. The AR slot only refills while arvalid is low, so
    // the handshake cycle itself is never a refill cycle: this guarantees at
    // least one idle cycle between AR handshakes.
    // ------------------------------------------------------------------
    assign w_slot_free   = !r_arvalid;

    assign w_data_rd_acc = !reset && data_req && !data_wr && w_slot_free
                           && (r_cnt_d < c_max_rd) && !r_wr_busy;

    assign w_inst_rd_acc = !reset && inst_req && w_slot_free
                           && (r_cnt_i < c_max_rd) && !w_data_rd_acc;

    // A write waits until every data read has returned; the slot test is
    // redundant with the counter today but keeps the rule local.
    assign w_wr_acc      = !reset && data_req && data_wr && !r_wr_busy
                           && (r_cnt_d == '0)
                           && !(r_arvalid && (r_arid == c_data_id));

    assign inst_addr_ok  = w_inst_rd_acc;
    assign data_addr_ok  = w_data_rd_acc || w_wr_acc;

    // ------------------------------------------------------------------
    // Read data return. Beats with an unknown ID, or for a port with
    // nothing outstanding (e.g. left over from before a reset), are
    // accepted and silently dropped.
    // ------------------------------------------------------------------
    assign w_r_hs       = !reset && rvalid && r_rready;
    assign w_inst_rok   = w_r_hs && (rid == c_inst_id) && (r_cnt_i != '0);
    assign w_data_rok   = w_r_hs && (rid == c_data_id) && (r_cnt_d != '0);

    // The B response is held off while a data-ID read beat is on the bus so
    // the data port never sees two completions in the same cycle.
    assign w_bready     = !reset && r_wr_busy && !r_awvalid && !r_wvalid
                          && !(rvalid && (rid == c_data_id));
    assign w_b_hs       = bvalid && w_bready;

    assign inst_data_ok = w_inst_rok;
    assign data_data_ok = w_data_rok || w_b_hs;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // ------------------------------------------------------------------
    // AR slot register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arsize  <= '0;
            r_arid    <= '0;
        end else if (w_data_rd_acc) begin
            r_arvalid <= 1'b1;
            r_araddr  <= data_addr;
            r_arsize  <= data_size;
            r_arid    <= c_data_id;
        end else if (w_inst_rd_acc) begin
            r_arvalid <= 1'b1;
            r_araddr  <= inst_addr;
            r_arsize  <= inst_size;
            r_arid    <= c_inst_id;
        end else if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read counters and rready
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rready <= 1'b0;
            r_cnt_i  <= '0;
            r_cnt_d  <= '0;
        end else begin
            r_rready <= 1'b1;
            case ({w_inst_rd_acc, w_inst_rok})
                2'b10:   r_cnt_i <= r_cnt_i + 1'b1;
                2'b01:   r_cnt_i <= r_cnt_i - 1'b1;
                default: r_cnt_i <= r_cnt_i;
            endcase
            case ({w_data_rd_acc, w_data_rok})
                2'b10:   r_cnt_d <= r_cnt_d + 1'b1;
                2'b01:   r_cnt_d <= r_cnt_d - 1'b1;
                default: r_cnt_d <= r_cnt_d;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write path: AW and W are launched together and retire independently;
    // the write stays busy until its B response is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_busy <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_awsize  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_wr_acc) begin
            r_wr_busy <= 1'b1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= data_addr;
            r_awsize  <= data_size;
            r_wdata   <= data_wdata;
            r_wstrb   <= data_wstrb;
        end else begin
            if (r_awvalid && awready) begin
                r_awvalid <= 1'b0;
            end
            if (r_wvalid && wready) begin
                r_wvalid <= 1'b0;
            end
            if (w_b_hs) begin
                r_wr_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output mapping; all transfers are single-beat INCR, normal access
    // ------------------------------------------------------------------
    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arlen   = 4'd0;
    assign arsize  = r_arsize;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = c_data_id;
    assign awaddr  = r_awaddr;
    assign awlen   = 4'd0;
    assign awsize  = r_awsize;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = r_awvalid;

    assign wid     = c_data_id;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wlast   = 1'b1;
    assign wvalid  = r_wvalid;

    assign bready  = w_bready;

endmodule
`default_nettype wire
